regfile_scoreboarded: RTL



---
 rtl/regfile_scoreboarded_pkg.sv | 24 ++
 rtl/regfile_scoreboarded_if.sv | 29 ++
 rtl/regfile_scoreboarded_scoreboard.sv | 49 ++++
 rtl/regfile_scoreboarded.sv | 73 +++++++
 4 files changed

// File: rtl/regfile_scoreboarded_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// The REGFILE_BYPASS_EN build option is consumed by the top level, not here.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_DEPTH    = 32;
  localparam int unsigned DEF_NUM_READ = 2;

  // Index 0 is the hardwired-zero register.
  localparam int unsigned REG_ZERO = 0;

  // Widest pending vector popcount accepts; narrower vectors are zero-extended.
  localparam int unsigned POP_MAX_W = 1024;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] vec);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      cnt += 32'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/regfile_scoreboarded_if.sv
// Decode/writeback bundle for regfile_scoreboarded. There is no handshake:
// issue and write take effect on every rising edge where their enable is 1.
interface regfile_scoreboarded_if #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_READ = 2
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [NUM_READ*ADDR_W-1:0] ReadRegister;
  logic [NUM_READ*DATA_W-1:0] ReadData;
  logic [NUM_READ-1:0]        ReadPending;
  logic                       IssueValid;
  logic [ADDR_W-1:0]          IssueRegister;
  logic                       RegWrite;
  logic [ADDR_W-1:0]          WriteRegister;
  logic [DATA_W-1:0]          WriteData;
  logic [ADDR_W:0]            PendingCount;

  modport master (
    output ReadRegister, IssueValid, IssueRegister, RegWrite, WriteRegister, WriteData,
    input  ReadData, ReadPending, PendingCount
  );

  modport slave (
    input  ReadRegister, IssueValid, IssueRegister, RegWrite, WriteRegister, WriteData,
    output ReadData, ReadPending, PendingCount
  );
endinterface

// File: rtl/regfile_scoreboarded_scoreboard.sv
// Per-register pending-write bits with issue-over-retire priority, plus a
// registered population count that moves on the same edge as the bits.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_issue_valid,
  input  logic [ADDR_W-1:0] i_issue_reg,
  input  logic              i_clr_valid,
  input  logic [ADDR_W-1:0] i_clr_reg,
  output logic [DEPTH-1:0]  o_pending,
  output logic [ADDR_W:0]   o_pending_count
);

  logic [DEPTH-1:0] r_pending;
  logic [ADDR_W:0]  r_count;
  logic [DEPTH-1:0] w_pend_next;
  logic [ADDR_W:0]  w_count_next;

  // Clear first, then set: a new producer supersedes the retiring one.
  always_comb begin
    w_pend_next = r_pending;
    if (i_clr_valid && (i_clr_reg != ADDR_W'(REG_ZERO))) begin
      w_pend_next[i_clr_reg] = 1'b0;
    end
    if (i_issue_valid && (i_issue_reg != ADDR_W'(REG_ZERO))) begin
      w_pend_next[i_issue_reg] = 1'b1;
    end
    w_count_next = (ADDR_W+1)'(popcount(POP_MAX_W'(w_pend_next)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_count   <= '0;
    end else begin
      r_pending <= w_pend_next;
      r_count   <= w_count_next;
    end
  end

  assign o_pending       = r_pending;
  assign o_pending_count = r_count;

endmodule

// File: rtl/regfile_scoreboarded.sv
// Register file with NUM_READ combinational read ports, one write port and a
// RAW-hazard scoreboard. Define REGFILE_BYPASS_EN to forward WriteData to reads.
module regfile_scoreboarded
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_READ = DEF_NUM_READ,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input logic                   clk,
  input logic                   rst,
  regfile_scoreboarded_if.slave rf_if
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0]          r_regs [DEPTH];
  logic [DEPTH-1:0]           w_pending;
  logic [ADDR_W-1:0]          w_idx  [NUM_READ];
  logic [NUM_READ*DATA_W-1:0] w_read_data;
  logic [NUM_READ-1:0]        w_read_pend;
  logic                       w_wr_en;

  assign w_wr_en = rf_if.RegWrite && (rf_if.WriteRegister != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[rf_if.WriteRegister] <= rf_if.WriteData;
    end
  end

  regfile_scoreboard #(.DEPTH(DEPTH)) u_scoreboard (
    .clk             (clk),
    .rst             (rst),
    .i_issue_valid   (rf_if.IssueValid),
    .i_issue_reg     (rf_if.IssueRegister),
    .i_clr_valid     (rf_if.RegWrite),
    .i_clr_reg       (rf_if.WriteRegister),
    .o_pending       (w_pending),
    .o_pending_count (rf_if.PendingCount)
  );

  // A bypassed port stays pending only if a new producer issues this cycle.
  always_comb begin
    w_read_data = '0;
    w_read_pend = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      w_idx[p] = rf_if.ReadRegister[p*ADDR_W +: ADDR_W];
      if (w_idx[p] != ADDR_W'(REG_ZERO)) begin
        if (BYPASS && w_wr_en && (rf_if.WriteRegister == w_idx[p])) begin
          w_read_data[p*DATA_W +: DATA_W] = rf_if.WriteData;
          w_read_pend[p] = rf_if.IssueValid && (rf_if.IssueRegister == w_idx[p]);
        end else begin
          w_read_data[p*DATA_W +: DATA_W] = r_regs[w_idx[p]];
          w_read_pend[p] = w_pending[w_idx[p]];
        end
      end
    end
  end

  assign rf_if.ReadData    = w_read_data;
  assign rf_if.ReadPending = w_read_pend;

endmodule
